// File: rtl/l2_cache.sv
// Two-way set-associative write-back L2: 8 sets of 16-byte lines, one LRU bit per set.
// Hits complete combinationally in CHECK; misses go through WRITEBACK and/or ALLOCATE.
module l2_cache (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);
    localparam logic [1:0] CHECK     = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0]   state_reg, state_next;
    logic         victim_reg, victim_next;
    logic         valid_reg [2][8];
    logic         dirty_reg [2][8];
    logic [7:0]   lru_reg;
    logic [8:0]   tag_arr   [2][8];
    logic [127:0] data_arr  [2][8];

    logic [2:0]   idx;
    logic [8:0]   req_tag;
    logic         req;
    logic [1:0]   way_hit;
    logic         hit, hit_way, victim_sel, victim_dirty;

    logic         line_we, line_way, line_dirty;
    logic [8:0]   line_tag;
    logic [127:0] line_data;
    logic         touch, touch_way, clean_we;

    // Offset bits select a byte within the line; whole-line transfers never need them.
    logic unused_offset;
    assign unused_offset = ^mem_address[3:0];

    assign idx     = mem_address[6:4];
    assign req_tag = mem_address[15:7];
    assign req     = mem_read | mem_write;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign way_hit[gi] = valid_reg[gi][idx] && (tag_arr[gi][idx] == req_tag);
        end
    endgenerate

    assign hit          = |way_hit;
    assign hit_way      = way_hit[1];
    assign victim_sel   = !valid_reg[0][idx] ? 1'b0 :
                          !valid_reg[1][idx] ? 1'b1 : lru_reg[idx];
    assign victim_dirty = valid_reg[victim_sel][idx] & dirty_reg[victim_sel][idx];

    assign mem_rdata  = data_arr[hit_way][idx];
    assign pmem_wdata = data_arr[victim_reg][idx];

    always_comb begin
        state_next   = state_reg;
        victim_next  = victim_reg;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        line_we      = 1'b0;
        line_way     = 1'b0;
        line_dirty   = 1'b0;
        line_tag     = req_tag;
        line_data    = mem_wdata;
        touch        = 1'b0;
        touch_way    = 1'b0;
        clean_we     = 1'b0;
        case (state_reg)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        touch     = 1'b1;
                        touch_way = hit_way;
                        if (mem_write) begin
                            line_we    = 1'b1;
                            line_way   = hit_way;
                            line_dirty = 1'b1;
                        end
                    end else if (victim_dirty) begin
                        victim_next = victim_sel;
                        state_next  = WRITEBACK;
                    end else if (mem_write) begin
                        // Full-line write: no fill needed, install straight into the victim.
                        mem_resp   = 1'b1;
                        line_we    = 1'b1;
                        line_way   = victim_sel;
                        line_dirty = 1'b1;
                        touch      = 1'b1;
                        touch_way  = victim_sel;
                    end else begin
                        victim_next = victim_sel;
                        state_next  = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[victim_reg][idx], idx, 4'b0000};
                if (pmem_resp) begin
                    clean_we   = 1'b1;
                    state_next = mem_write ? CHECK : ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, idx, 4'b0000};
                if (pmem_resp) begin
                    line_we    = 1'b1;
                    line_way   = victim_reg;
                    line_data  = pmem_rdata;
                    state_next = CHECK;
                end
            end
            default: state_next = CHECK;
        endcase
        if (reset) begin
            mem_resp = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= CHECK;
            victim_reg <= 1'b0;
            lru_reg    <= 8'h00;
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < 8; s++) begin
                    valid_reg[w][s] <= 1'b0;
                    dirty_reg[w][s] <= 1'b0;
                end
            end
        end else begin
            state_reg  <= state_next;
            victim_reg <= victim_next;
            if (line_we) begin
                valid_reg[line_way][idx] <= 1'b1;
                dirty_reg[line_way][idx] <= line_dirty;
            end
            if (clean_we) begin
                dirty_reg[victim_reg][idx] <= 1'b0;
            end
            if (touch) begin
                lru_reg[idx] <= ~touch_way;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (line_we && !reset) begin
            tag_arr[line_way][idx]  <= line_tag;
            data_arr[line_way][idx] <= line_data;
        end
    end
endmodule

// File: tb/tb_l2_cache.sv
// Directed self-checking bench for l2_cache: hits, clean/dirty misses, write allocate,
// reset abort of an in-flight fill, and read+write priority.
module tb_l2_cache;
    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] DC = {4{32'hCCCC_0003}};
    localparam logic [127:0] DD = {4{32'hDDDD_0004}};
    localparam logic [127:0] E0 = {4{32'hE000_0030}};
    localparam logic [127:0] E1 = {4{32'hE001_0130}};
    localparam logic [127:0] W2 = {4{32'h5702_0230}};
    localparam logic [127:0] E3 = {4{32'hE003_0330}};
    localparam logic [127:0] DF = {4{32'hFFFF_0240}};
    localparam logic [127:0] DG = {4{32'h6666_0050}};
    localparam logic [127:0] DH = {4{32'h4848_0050}};
    localparam logic [127:0] DJ = {4{32'h1A1A_0050}};
    localparam logic [127:0] DK = {4{32'h2B2B_00D0}};
    localparam logic [127:0] DL = {4{32'h3C3C_0150}};

    l2_cache dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] d);
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d;
        #1;
        $display("req rd=%0d wr=%0d addr=%h resp=%0d", rd, wr, a, mem_resp);
    endtask

    task automatic drop();
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
    endtask

    task automatic pm_done(input logic [127:0] d);
        pmem_rdata = d; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        mem_address = 16'h0; mem_wdata = '0; pmem_rdata = '0;
        do_reset();
        check("reset_mem_resp", 128'(mem_resp), 128'd0);
        check("reset_pmem_read", 128'(pmem_read), 128'd0);
        check("reset_pmem_write", 128'(pmem_write), 128'd0);
        check("reset_pmem_addr", 128'(pmem_address), 128'd0);

        // Cold read miss, fill, then a repeat hit
        req(1, 0, 16'h1230, '0);
        check("cold_miss_resp", 128'(mem_resp), 128'd0);
        tick();
        check("alloc_pmem_read", 128'(pmem_read), 128'd1);
        check("alloc_pmem_write", 128'(pmem_write), 128'd0);
        check("alloc_addr", 128'(pmem_address), 128'h1230);
        pm_done(DA);
        check("fill_resp", 128'(mem_resp), 128'd1);
        check("fill_rdata", mem_rdata, DA);
        drop();
        req(1, 0, 16'h1230, '0);
        check("rehit_resp", 128'(mem_resp), 128'd1);
        check("rehit_rdata", mem_rdata, DA);
        check("rehit_no_pmem", 128'({pmem_read, pmem_write}), 128'd0);
        drop();

        // Write hit, then read back
        req(0, 1, 16'h1230, DB);
        check("wrhit_resp", 128'(mem_resp), 128'd1);
        check("wrhit_no_pmem", 128'({pmem_read, pmem_write}), 128'd0);
        drop();
        req(1, 0, 16'h1230, '0);
        check("wrhit_readback", mem_rdata, DB);
        drop();

        // Set 3 conflict sequence
        do_reset();
        req(1, 0, 16'h0030, '0);
        tick();
        check("s3_alloc0_addr", 128'(pmem_address), 128'h0030);
        pm_done(E0);
        check("s3_fill0", mem_rdata, E0);
        drop();
        req(1, 0, 16'h0130, '0);
        tick();
        check("s3_alloc1_addr", 128'(pmem_address), 128'h0130);
        pm_done(E1);
        check("s3_fill1", mem_rdata, E1);
        drop();
        req(0, 1, 16'h0230, W2);
        check("s3_wralloc_resp", 128'(mem_resp), 128'd1);
        check("s3_wralloc_no_pmem", 128'({pmem_read, pmem_write}), 128'd0);
        drop();
        req(1, 0, 16'h0230, '0);
        check("s3_wralloc_read", mem_rdata, W2);
        drop();
        req(1, 0, 16'h0330, '0);
        check("s3_miss330_resp", 128'(mem_resp), 128'd0);
        tick();
        check("s3_clean_evict_no_wb", 128'(pmem_write), 128'd0);
        check("s3_alloc3_read", 128'(pmem_read), 128'd1);
        check("s3_alloc3_addr", 128'(pmem_address), 128'h0330);
        pm_done(E3);
        check("s3_fill3", mem_rdata, E3);
        drop();
        req(1, 0, 16'h0130, '0);
        check("s3_0130_evicted", 128'(mem_resp), 128'd0);
        tick();
        check("s3_wb230_write", 128'(pmem_write), 128'd1);
        check("s3_wb230_addr", 128'(pmem_address), 128'h0230);
        check("s3_wb230_data", pmem_wdata, W2);
        do_reset();
        check("wb_abort_write", 128'(pmem_write), 128'd0);

        // Dirty eviction in set 4
        req(0, 1, 16'h0040, DC);
        check("s4_wrC_resp", 128'(mem_resp), 128'd1);
        drop();
        req(0, 1, 16'h0140, DD);
        check("s4_wrD_resp", 128'(mem_resp), 128'd1);
        drop();
        req(1, 0, 16'h0140, '0);
        check("s4_touch_D", mem_rdata, DD);
        drop();
        req(1, 0, 16'h0240, '0);
        check("s4_miss_resp", 128'(mem_resp), 128'd0);
        tick();
        check("s4_wb_write", 128'(pmem_write), 128'd1);
        check("s4_wb_read_low", 128'(pmem_read), 128'd0);
        check("s4_wb_addr", 128'(pmem_address), 128'h0040);
        check("s4_wb_data", pmem_wdata, DC);
        tick();
        check("s4_wb_held", 128'(pmem_write), 128'd1);
        pm_done('0);
        check("s4_alloc_read", 128'(pmem_read), 128'd1);
        check("s4_alloc_write_low", 128'(pmem_write), 128'd0);
        check("s4_alloc_addr", 128'(pmem_address), 128'h0240);
        check("s4_alloc_no_resp", 128'(mem_resp), 128'd0);
        pm_done(DF);
        check("s4_resp", 128'(mem_resp), 128'd1);
        check("s4_rdata", mem_rdata, DF);
        drop();

        // Reset during ALLOCATE, late pmem_resp must be ignored
        do_reset();
        req(1, 0, 16'h0050, '0);
        tick();
        check("rst_alloc_read", 128'(pmem_read), 128'd1);
        reset = 1'b1; mem_read = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rst_strobe_low", 128'(pmem_read), 128'd0);
        tick();
        pm_done(DG);
        check("rst_late_resp_ignored", 128'({pmem_read, mem_resp}), 128'd0);
        tick();
        req(1, 0, 16'h0050, '0);
        check("rst_remiss", 128'(mem_resp), 128'd0);
        tick();
        check("rst_realloc_addr", 128'(pmem_address), 128'h0050);
        pm_done(DH);
        check("rst_refill", mem_rdata, DH);
        drop();

        // Read and write together on a hit act as a write
        req(1, 1, 16'h0050, DJ);
        check("rw_resp", 128'(mem_resp), 128'd1);
        check("rw_no_pmem", 128'({pmem_read, pmem_write}), 128'd0);
        drop();
        req(1, 0, 16'h0050, '0);
        check("rw_data", mem_rdata, DJ);
        drop();
        req(1, 0, 16'h00D0, '0);
        tick();
        pm_done(DK);
        check("rw_fill_d0", mem_rdata, DK);
        drop();
        req(1, 0, 16'h0150, '0);
        tick();
        check("rw_dirty_wb", 128'(pmem_write), 128'd1);
        check("rw_wb_addr", 128'(pmem_address), 128'h0050);
        check("rw_wb_data", pmem_wdata, DJ);
        pm_done('0);
        check("rw_alloc_addr", 128'(pmem_address), 128'h0150);
        pm_done(DL);
        check("rw_fill_150", mem_rdata, DL);
        drop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
